pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage rv32i pipeline. It supersedes the PC-select-only hazard logic.
- Resolves control redirects from EX and detects RAW hazards (load-use only, or full RAW when forwarding is disabled).
- Handles imem/dmem response stalls and squashes wrong-path fetch responses that are in flight at redirect time.
- Drives PC enable/select and the enable/flush of every pipeline register. Also keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_hazard_ctrl_perf_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the rv32i pipeline control path.
//   rv32i_opcode    : base opcode field encodings
//   pcmux_sel_t     : next-PC source select
//   hazctl_state_t  : hazard controller fetch-tracking state
//   redirect_sel()  : maps a redirecting EX opcode to its next-PC source
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hazctl_state_t;

  localparam int NUM_PERF      = 3;
  localparam int PERF_STALL    = 0;
  localparam int PERF_REDIRECT = 1;
  localparam int PERF_SQUASH   = 2;

  // jalr targets need bit 0 cleared, hence the separate mod2 path.
  function automatic pcmux_sel_t redirect_sel(rv32i_opcode op);
    case (op)
      op_jal:  return alu_out;
      op_jalr: return alu_mod2;
      op_br:   return alu_out;
      default: return pc_plus4;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event this cycle
//   cnt        : current count, sticks at all-ones
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline.
//   imem_resp, dmem_resp, mem_req   : memory handshake status
//   ex_opcode, br_en                : EX control-transfer info
//   ex_/mem_regwrite, ex_/mem_rd    : producers in EX and MEM
//   id_rs1/2, id_use_rs1/2          : consumer in ID
//   perf_clr                        : clear performance counters
//   pc_en, pcmux_sel                : PC load and source
//   *_en, *_flush                   : pipeline register enables / bubble loads
//   stall_cnt, redirect_cnt, squash_cnt : saturating event counters
// Control outputs are combinational; only the squash state and counters are
// registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 32,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_req,
  input  rv32i_opcode      ex_opcode,
  input  logic             br_en,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             perf_clr,
  output logic             pc_en,
  output pcmux_sel_t       pcmux_sel,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  hazctl_state_t state, state_nxt;
  logic [NUM_PERF-1:0]            perf_inc;
  logic [NUM_PERF-1:0][CNT_W-1:0] perf_cnt;

  // x0 never carries a dependency.
  function automatic logic id_reads(logic [REG_W-1:0] rd);
    return (rd != '0) && ((id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd));
  endfunction

  logic mem_stall, redirect, load_use, raw_any, data_haz;

  assign mem_stall = mem_req & ~dmem_resp;
  assign redirect  = (ex_opcode == op_jal) | (ex_opcode == op_jalr) |
                     ((ex_opcode == op_br) & br_en);
  assign load_use  = (ex_opcode == op_load) & ex_regwrite & id_reads(ex_rd);
  assign raw_any   = (ex_regwrite & id_reads(ex_rd)) | (mem_regwrite & id_reads(mem_rd));
  assign data_haz  = (FORWARD_EN != 0) ? load_use : raw_any;

  always_comb begin
    pc_en      = 1'b0;
    pcmux_sel  = pc_plus4;
    IFID_en    = 1'b0;
    IDEX_en    = 1'b0;
    EXMEM_en   = 1'b0;
    MEMWB_en   = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    perf_inc   = '0;
    state_nxt  = state;
    if (!rst_n) begin
      state_nxt = RUN;
    end else if (mem_stall) begin
      // Whole pipe frozen; a pending redirect in EX is re-seen next cycle.
      perf_inc[PERF_STALL] = 1'b1;
    end else if (redirect) begin
      pc_en      = 1'b1;
      pcmux_sel  = redirect_sel(ex_opcode);
      {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
      perf_inc[PERF_REDIRECT] = 1'b1;
      // The fetch issued before the redirect is still in flight: drop it later.
      // Already in SQUASH means that one response is still owed; stay.
      if (state == RUN && !imem_resp) state_nxt = SQUASH;
    end else if (state == SQUASH) begin
      {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
      IFID_flush = 1'b1;
      if (imem_resp) begin
        perf_inc[PERF_SQUASH] = 1'b1;
        state_nxt = RUN;
      end
    end else if (data_haz) begin
      // Hold PC and ID, push a bubble into EX.
      {IDEX_en, EXMEM_en, MEMWB_en} = '1;
      IDEX_flush = 1'b1;
      perf_inc[PERF_STALL] = 1'b1;
    end else if (!imem_resp) begin
      {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
      IFID_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
      {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  for (genvar g = 0; g < NUM_PERF; g++) begin : g_perf
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (perf_clr),
      .inc   (perf_inc[g]),
      .cnt   (perf_cnt[g])
    );
  end

  assign stall_cnt    = perf_cnt[PERF_STALL];
  assign redirect_cnt = perf_cnt[PERF_REDIRECT];
  assign squash_cnt   = perf_cnt[PERF_SQUASH];

endmodule
